timer_irq_ctrl: RTL and testbench

Memory-mapped interval timer and interrupt sequencer for the single-cycle CPU. It owns the TH/TL/TCON peripheral registers on the data-memory bus and drives the `irq` input of the Control unit. A three-state handshake with the datapath ensures each timer interrupt is requested once, acknowledged once and masked until the handler returns.

---
 rtl/timer_irq_ctrl.sv | 152 +++++++++++++++
 tb/tb_timer_irq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
// Interval timer with TH/TL/TCON bus registers
// and a PEND/SERV interrupt handshake toward Control.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] TH_RESET  = 32'h0000_0000,
  parameter logic [31:0] TL_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        irq_ack,
  input  logic        iret,
  output logic        in_service
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    SERV = 2'b10
  } state_t;

  state_t state;
  state_t stateNext;

  logic [31:0] th;
  logic [31:0] tl;
  logic        en;
  logic        ie;
  logic        st;
  logic        ovr;

  logic selTh;
  logic selTl;
  logic selTcon;
  logic wrTh;
  logic wrTl;
  logic wrTcon;
  logic tick;
  logic ovf;
  logic setSt;
  logic setOvr;
  logic want;

  assign selTh   = (addr == BASE_ADDR);
  assign selTl   = (addr == BASE_ADDR + 32'd4);
  assign selTcon = (addr == BASE_ADDR + 32'd8);

  assign wrTh   = mem_write & selTh;
  assign wrTl   = mem_write & selTl;
  assign wrTcon = mem_write & selTcon;

  // a bus write to TL suppresses this cycle's count
  assign tick   = en & ~wrTl;
  assign ovf    = tick & (tl == 32'hFFFF_FFFF);
  assign setSt  = ovf & ie;
  assign setOvr = setSt & st;
  assign want   = st & ie;

  // reload value register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= TH_RESET;
    end else if (wrTh) begin
      th <= wdata;
    end
  end

  // counter: bus write wins, else count or reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tl <= TL_RESET;
    end else if (wrTl) begin
      tl <= wdata;
    end else if (tick) begin
      tl <= ovf ? th : tl + 32'd1;
    end
  end

  // control/status; overflow sets OR into any write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en  <= 1'b0;
      ie  <= 1'b0;
      st  <= 1'b0;
      ovr <= 1'b0;
    end else if (wrTcon) begin
      en  <= wdata[0];
      ie  <= wdata[1];
      st  <= wdata[2] | setSt;
      ovr <= wdata[3] | setOvr;
    end else begin
      st  <= st | setSt;
      ovr <= ovr | setOvr;
    end
  end

  // handshake state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // handshake next-state; ack beats a software abort
  always_comb begin
    stateNext = IDLE;
    case (state)
      IDLE: stateNext = want ? PEND : IDLE;
      PEND: begin
        if (irq_ack) begin
          stateNext = SERV;
        end else if (!want) begin
          stateNext = IDLE;
        end else begin
          stateNext = PEND;
        end
      end
      SERV: begin
        if (iret) begin
          stateNext = want ? PEND : IDLE;
        end else begin
          stateNext = SERV;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign irq        = (state == PEND);
  assign in_service = (state == SERV);

  // combinational read mux
  always_comb begin
    rdata = 32'h0;
    if (mem_read) begin
      unique case (1'b1)
        selTh:   rdata = th;
        selTl:   rdata = tl;
        selTcon: rdata = {28'h0, ovr, st, ie, en};
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: cycle model plus
// directed handshake, overrun and collision cases.
module tb_timer_irq_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata;
  logic        irq;
  logic        irq_ack;
  logic        iret;
  logic        in_service;

  int checks = 0;
  int failures = 0;
  int n;

  logic [31:0] mTh = 32'h0;
  logic [31:0] mTl = 32'h0;
  logic [3:0]  mTcon = 4'h0;
  logic        mIrq = 1'b0;
  logic        mServ = 1'b0;

  timer_irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .rdata      (rdata),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .iret       (iret),
    .in_service (in_service)
  );

  always #10 clk = ~clk;

  task automatic check32(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: one clock of the register/handshake rules
  task automatic modelStep();
    logic [31:0] nTl;
    logic [3:0]  nTcon;
    logic        ovf;
    logic        want;
    logic        nIrq;
    logic        nServ;
    want  = mTcon[2] & mTcon[1];
    ovf   = 1'b0;
    nTl   = mTl;
    nTcon = mTcon;
    if (mem_write && addr == BASE + 32'd4) nTl = wdata;
    else if (mTcon[0]) begin
      if (mTl == 32'hFFFF_FFFF) begin
        nTl = mTh;
        ovf = 1'b1;
      end else nTl = mTl + 32'd1;
    end
    if (mem_write && addr == BASE + 32'd8) nTcon = wdata[3:0];
    if (ovf && mTcon[1]) begin
      if (mTcon[2]) nTcon[3] = 1'b1;
      nTcon[2] = 1'b1;
    end
    nIrq  = mIrq;
    nServ = mServ;
    if (mServ) begin
      if (iret) begin
        nServ = 1'b0;
        nIrq  = want;
      end
    end else if (mIrq) begin
      if (irq_ack) begin
        nIrq  = 1'b0;
        nServ = 1'b1;
      end else if (!want) nIrq = 1'b0;
    end else nIrq = want;
    if (mem_write && addr == BASE) mTh <= wdata;
    mTl   <= nTl;
    mTcon <= nTcon;
    mIrq  <= nIrq;
    mServ <= nServ;
  endtask

  function automatic logic [31:0] expRdata();
    if (!mem_read) return 32'h0;
    if (addr == BASE) return mTh;
    if (addr == BASE + 32'd4) return mTl;
    if (addr == BASE + 32'd8) return {28'h0, mTcon};
    return 32'h0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mTh   <= 32'h0;
      mTl   <= 32'h0;
      mTcon <= 4'h0;
      mIrq  <= 1'b0;
      mServ <= 1'b0;
    end else begin
      modelStep();
    end
  end

  always @(negedge clk) begin
    check32("cyc_irq", {31'h0, irq}, {31'h0, mIrq});
    check32("cyc_serv", {31'h0, in_service}, {31'h0, mServ});
    check32("cyc_rdata", rdata, expRdata());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    addr = 32'h0;
    wdata = 32'h0;
    mem_write = 1'b0;
    mem_read = 1'b0;
    irq_ack = 1'b0;
    iret = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    idle();
    addr = a;
    wdata = d;
    mem_write = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string name);
    idle();
    addr = a;
    mem_read = 1'b1;
    #2;
    check32(name, rdata, exp);
    tick();
    idle();
  endtask

  task automatic pulseAck();
    idle();
    irq_ack = 1'b1;
    tick();
    idle();
  endtask

  task automatic pulseIret();
    idle();
    iret = 1'b1;
    tick();
    idle();
  endtask

  task automatic waitIrq(input logic v, input int maxc, output int cnt);
    cnt = 0;
    while (irq !== v && cnt < maxc) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #1 reset = 1'b0;
    repeat (3) tick();
    check32("irq_in_reset", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    tick();
    rd(BASE, 32'h0, "th_reset");
    rd(BASE + 32'd4, 32'h0, "tl_reset");
    rd(BASE + 32'd8, 32'h0, "tcon_reset");
    wr(BASE, 32'hFFFF_FFFC);
    rd(BASE, 32'hFFFF_FFFC, "th_readback");
    rd(BASE + 32'd12, 32'h0, "unmapped");
    rd(BASE + 32'd1, 32'h0, "misaligned");

    wr(BASE + 32'd4, 32'hFFFF_FFFC);
    wr(BASE + 32'd8, 32'h3);
    waitIrq(1'b1, 20, n);
    check32("irq_latency", n, 5);
    rd(BASE + 32'd8, 32'h7, "st_set");
    check32("irq_hold1", {31'h0, irq}, 32'h1);
    tick();
    check32("irq_hold2", {31'h0, irq}, 32'h1);
    pulseAck();
    check32("ack_serv", {30'h0, irq, in_service}, 32'h1);
    wr(BASE + 32'd8, 32'h3);
    pulseIret();
    check32("iret_idle", {30'h0, irq, in_service}, 32'h0);
    waitIrq(1'b1, 10, n);
    check32("irq_period", n, 3);
    pulseAck();
    pulseIret();
    check32("iret_repend", {30'h0, irq, in_service}, 32'h2);
    pulseAck();
    check32("serv_again", {30'h0, irq, in_service}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check32("serv_no_irq", {30'h0, irq, in_service}, 32'h1);
    end
    rd(BASE + 32'd8, 32'hF, "ovr_set");
    wr(BASE + 32'd8, 32'hE);
    pulseIret();
    check32("iret_pend_ovr", {30'h0, irq, in_service}, 32'h2);
    wr(BASE + 32'd8, 32'h2);
    check32("pend_before_abort", {31'h0, irq}, 32'h1);
    tick();
    check32("abort_idle", {30'h0, irq, in_service}, 32'h0);
    repeat (3) tick();
    check32("abort_stay", {31'h0, irq}, 32'h0);

    wr(BASE + 32'd8, 32'h0);
    wr(BASE + 32'd4, 32'hFFFF_FFFF);
    wr(BASE + 32'd8, 32'h3);
    wr(BASE + 32'd4, 32'h5);
    rd(BASE + 32'd4, 32'h5, "tl_write_wins");
    rd(BASE + 32'd8, 32'h3, "st_unchanged");
    check32("no_irq_collision", {31'h0, irq}, 32'h0);

    wr(BASE + 32'd8, 32'h0);
    wr(BASE + 32'd4, 32'hFFFF_FFFF);
    wr(BASE + 32'd8, 32'h3);
    wr(BASE + 32'd8, 32'h3);
    rd(BASE + 32'd8, 32'h7, "tcon_collision");
    waitIrq(1'b1, 5, n);
    check32("collision_irq", {31'h0, irq}, 32'h1);
    pulseAck();
    check32("serv_before_reset", {30'h0, irq, in_service}, 32'h1);

    #1 reset = 1'b0;
    #1;
    check32("async_clear", {30'h0, irq, in_service}, 32'h0);
    mem_read = 1'b1;
    addr = BASE;
    #1 check32("th_async", rdata, 32'h0);
    addr = BASE + 32'd4;
    #1 check32("tl_async", rdata, 32'h0);
    addr = BASE + 32'd8;
    #1 check32("tcon_async", rdata, 32'h0);
    idle();
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check32("irq_after_reset", {31'h0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
